riscv_ctrl_fsm: RTL

- Multi-cycle control sequencer for the RV32I-subset datapath.
- Owns the program counter and fetches instruction words from instruction memory over a valid handshake.
- Decodes each word and drives every datapath control port for exactly the cycles that instruction needs; samples the datapath branch flags to resolve control flow.
- Sits between instruction memory and the datapath; one instruction in flight at a time.

---
 rtl/riscv_ctrl_fsm.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/riscv_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM control sequencer for an RV32I-subset datapath.
// Define CTRL_ILLEGAL_TRAP_EN to trap on unsupported encodings; otherwise they execute as NOPs.
module riscv_ctrl_fsm #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [4:0]  read_reg_num1,
    output logic [4:0]  read_reg_num2,
    output logic [4:0]  write_reg_num1,
    output logic [5:0]  alu_control,
    output logic [31:0] imm_val,
    output logic [31:0] imm_val_lui,
    output logic [3:0]  sh_amt,
    output logic        alu_src,
    output logic        lb,
    output logic        sw,
    output logic        jump,
    output logic        lui_control,
    output logic        beq_control,
    output logic        bne_control,
    output logic        bgeq_control,
    output logic        blt_control,
    input  logic        beq,
    input  logic        bneq,
    input  logic        bge,
    input  logic        blt,
    output logic [31:0] pc,
    output logic        retire,
    output logic [31:0] instret,
    output logic        halted
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic        trap
`endif
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [5:0] ALU_ADD = 6'd1, ALU_SUB = 6'd2, ALU_AND = 6'd3, ALU_OR = 6'd4;
    localparam logic [5:0] ALU_XOR = 6'd5, ALU_SLL = 6'd6, ALU_SRL = 6'd7, ALU_SLT = 6'd8;
    localparam logic [5:0] ALU_EQ = 6'd9, ALU_NE = 6'd10, ALU_GE = 6'd11, ALU_LT = 6'd12;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, HALT
`ifdef CTRL_ILLEGAL_TRAP_EN
        , TRAP
`endif
    } state_t;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [5:0]  alu;
        logic [31:0] imm;
        logic [31:0] imm_lui;
        logic [3:0]  sh;
        logic        alu_src;
        logic        jump;
        logic        lui;
        logic        beq_c;
        logic        bne_c;
        logic        bge_c;
        logic        blt_c;
        logic        load;
        logic        store;
        logic        ecall;
    } ctrl_t;

    state_t      state, state_nxt;
    logic        started;
    logic [31:0] ir;
    ctrl_t       dec, ctrl;
    logic        dec_illegal;
    logic        drive, taken;
    logic [31:0] j_imm, pc_nxt;

    always_comb begin
        dec         = '0;
        dec_illegal = 1'b0;
        case (ir[6:0])
            OP_R: begin
                dec.rs1 = ir[19:15];
                dec.rs2 = ir[24:20];
                dec.rd  = ir[11:7];
                case ({ir[31:25], ir[14:12]})
                    {7'h00, 3'd0}: dec.alu = ALU_ADD;
                    {7'h20, 3'd0}: dec.alu = ALU_SUB;
                    {7'h00, 3'd1}: dec.alu = ALU_SLL;
                    {7'h00, 3'd2}: dec.alu = ALU_SLT;
                    {7'h00, 3'd4}: dec.alu = ALU_XOR;
                    {7'h00, 3'd5}: dec.alu = ALU_SRL;
                    {7'h00, 3'd6}: dec.alu = ALU_OR;
                    {7'h00, 3'd7}: dec.alu = ALU_AND;
                    default:       dec_illegal = 1'b1;
                endcase
            end
            OP_IMM, OP_LOAD: begin
                dec.rs1     = ir[19:15];
                dec.rd      = ir[11:7];
                dec.imm     = {{20{ir[31]}}, ir[31:20]};
                dec.alu     = ALU_ADD;
                dec.alu_src = 1'b1;
                dec.load    = (ir[6:0] == OP_LOAD);
                dec_illegal = (ir[14:12] != ((ir[6:0] == OP_LOAD) ? 3'd2 : 3'd0));
            end
            OP_STORE: begin
                dec.rs1     = ir[19:15];
                dec.rs2     = ir[24:20];
                dec.imm     = {{20{ir[31]}}, ir[31:25], ir[11:7]};
                dec.alu     = ALU_ADD;
                dec.alu_src = 1'b1;
                dec.store   = 1'b1;
                dec_illegal = (ir[14:12] != 3'd2);
            end
            OP_BRANCH: begin
                dec.rs1 = ir[19:15];
                dec.rs2 = ir[24:20];
                dec.imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
                case (ir[14:12])
                    3'd0: begin dec.alu = ALU_EQ; dec.beq_c = 1'b1; end
                    3'd1: begin dec.alu = ALU_NE; dec.bne_c = 1'b1; end
                    3'd5: begin dec.alu = ALU_GE; dec.bge_c = 1'b1; end
                    3'd4: begin dec.alu = ALU_LT; dec.blt_c = 1'b1; end
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_LUI: begin
                dec.rd      = ir[11:7];
                dec.imm_lui = {ir[31:12], 12'b0};
                dec.lui     = 1'b1;
            end
            OP_JAL: begin
                dec.rd   = ir[11:7];
                dec.jump = 1'b1;
            end
            OP_SYSTEM: begin
                dec.ecall   = (ir == 32'h0000_0073);
                dec_illegal = (ir != 32'h0000_0073);
            end
            default: dec_illegal = 1'b1;
        endcase
        if (!dec.ecall) dec.sh = ir[23:20];
        // Unsupported encodings carry no controls, so without the trap they behave as a NOP.
        if (dec_illegal) dec = '0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:  if (imem_req && imem_valid) state_nxt = DECODE;
`ifdef CTRL_ILLEGAL_TRAP_EN
            DECODE: state_nxt = dec_illegal ? TRAP : EXEC;
`else
            DECODE: state_nxt = EXEC;
`endif
            EXEC: begin
                if (ctrl.ecall)                  state_nxt = HALT;
                else if (ctrl.load || ctrl.store) state_nxt = MEM;
                else                              state_nxt = FETCH;
            end
            MEM:     state_nxt = FETCH;
            default: state_nxt = state;
        endcase
    end

    assign j_imm  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    assign taken  = (ctrl.beq_c && beq) || (ctrl.bne_c && bneq) ||
                    (ctrl.bge_c && bge) || (ctrl.blt_c && blt);
    assign pc_nxt = taken     ? pc + ctrl.imm :
                    ctrl.jump ? pc + j_imm    : pc + 32'd4;
    // Gated by rst so an instruction aborted by reset never reports completion.
    assign retire = rst && ((state == EXEC && !ctrl.ecall && !ctrl.load && !ctrl.store) ||
                            state == MEM);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            instret <= '0;
            started <= 1'b0;
        end else begin
            state   <= state_nxt;
            started <= 1'b1;
            if (retire) begin
                pc      <= pc_nxt;
                instret <= instret + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (imem_req && imem_valid) ir <= imem_rdata;
        if (state == DECODE)        ctrl <= dec;
    end

    assign imem_req  = (state == FETCH) && run && started;
    assign imem_addr = imem_req ? pc : 32'd0;
    assign drive     = (state == EXEC) || (state == MEM);

    assign read_reg_num1  = drive ? ctrl.rs1     : 5'd0;
    assign read_reg_num2  = drive ? ctrl.rs2     : 5'd0;
    assign write_reg_num1 = drive ? ctrl.rd      : 5'd0;
    assign alu_control    = drive ? ctrl.alu     : 6'd0;
    assign imm_val        = drive ? ctrl.imm     : 32'd0;
    assign imm_val_lui    = drive ? ctrl.imm_lui : 32'd0;
    assign sh_amt         = drive ? ctrl.sh      : 4'd0;
    assign alu_src        = drive && ctrl.alu_src;
    assign jump           = drive && ctrl.jump;
    assign lui_control    = drive && ctrl.lui;
    assign beq_control    = drive && ctrl.beq_c;
    assign bne_control    = drive && ctrl.bne_c;
    assign bgeq_control   = drive && ctrl.bge_c;
    assign blt_control    = drive && ctrl.blt_c;
    assign lb             = (state == MEM) && ctrl.load;
    assign sw             = (state == MEM) && ctrl.store;

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign trap   = (state == TRAP);
    assign halted = (state == HALT) || (state == TRAP);
`else
    assign halted = (state == HALT);
`endif

endmodule
